// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN timestep scheduler.
package snn_pkg;

    localparam int N_AXONS_DEF   = 256;
    localparam int N_NEURONS_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FETCH,
        ST_INTEG,
        ST_FIRE,
        ST_CAPTURE
    } state_t;

    // Register word indices (byte offset >> 2) within the window.
    localparam logic [5:0] WORD_CTRL    = 6'h00;
    localparam logic [5:0] WORD_STATUS  = 6'h01;
    localparam logic [5:0] WORD_SPIKE   = 6'h02;
    localparam logic [5:0] WORD_AXON_IN = 6'h04;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_CLR_DONE = 2;

endpackage

// File: rtl/snn_sched_regs.sv
// Wishbone slave register file: decode, CTRL/STATUS/SPIKE_OUT/AXON_IN, ack and irq.
module snn_sched_regs
    import snn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_C000,
    parameter int          N_AXONS   = N_AXONS_DEF,
    parameter int          N_NEURONS = N_NEURONS_DEF,
    parameter int          AXON_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic                 busy,
    input  logic [AXON_W-1:0]    ptr,
    input  logic                 capture,
    input  logic [N_NEURONS-1:0] spike_i,
    output logic                 start,
    output logic [N_AXONS-1:0]   axon_in,
    output logic                 irq_o
);

    localparam int N_WORDS = N_AXONS / 32;
    localparam int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    logic                         ack_q;
    logic [31:0]                  dat_q;
    logic                         irq_en_q;
    logic                         done_q;
    logic                         irq_q;
    logic [15:0]                  ts_count_q;
    logic [N_NEURONS-1:0]         spike_out_q;
    logic [N_WORDS-1:0][31:0]     axon_words_q;

    logic        hit, req, wr, in_axon, ctrl_wr, clr_done;
    logic [5:0]  word;
    logic [WW-1:0] widx;
    logic [31:0] rdata;
    logic        unused_adr;

    assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
    assign wr       = req & wbs_we_i;
    assign word     = wbs_adr_i[7:2];
    assign widx     = WW'(word - WORD_AXON_IN);
    assign in_axon  = (word >= WORD_AXON_IN) && (word < WORD_AXON_IN + 6'(N_WORDS));
    assign ctrl_wr  = wr && (word == WORD_CTRL) && wbs_sel_i[0];
    // START is only honoured from idle so a stray START cannot clear DONE mid-run.
    assign start    = ctrl_wr && wbs_dat_i[CTRL_START] && !busy;
    assign clr_done = ctrl_wr && wbs_dat_i[CTRL_CLR_DONE];
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        rdata = '0;
        if (word == WORD_CTRL) begin
            rdata[CTRL_IRQ_EN] = irq_en_q;
        end else if (word == WORD_STATUS) begin
            rdata = {ts_count_q, 8'(ptr), 6'd0, done_q, busy};
        end else if (word == WORD_SPIKE) begin
            rdata = 32'(spike_out_q);
        end else if (in_axon) begin
            rdata = axon_words_q[widx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            ts_count_q   <= '0;
            spike_out_q  <= '0;
            axon_words_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= req ? rdata : '0;
            irq_q <= done_q & irq_en_q;
            if (ctrl_wr) begin
                irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (wr && in_axon && !busy) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) begin
                        axon_words_q[widx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                    end
                end
            end
            // Completion outranks a simultaneous CLR_DONE.
            if (capture) begin
                done_q      <= 1'b1;
                spike_out_q <= spike_i;
                ts_count_q  <= ts_count_q + 16'd1;
            end else if (start || clr_done) begin
                done_q <= 1'b0;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign axon_in   = axon_words_q;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences one SNN timestep: scan axons, fetch active rows, integrate, then fire and capture.
//   state   | meaning
//   IDLE    | waiting for START
//   SCAN    | test AXON_IN[ptr]; skip inactive axons
//   FETCH   | request synapse row ptr from the core
//   INTEG   | forward returned row as integrate enables
//   FIRE    | one leak/threshold/reset strobe
//   CAPTURE | latch spikes, bump TS_COUNT, set DONE
module snn_timestep_scheduler
    import snn_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_C000,
    parameter int          N_AXONS   = N_AXONS_DEF,
    parameter int          N_NEURONS = N_NEURONS_DEF,
    parameter int          AXON_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [AXON_W-1:0]    axon_idx_o,
    output logic                 axon_req_o,
    input  logic [N_NEURONS-1:0] conn_i,
    output logic [N_NEURONS-1:0] integrate_en_o,
    output logic                 fire_o,
    input  logic [N_NEURONS-1:0] spike_i,
    output logic                 busy_o,
    output logic                 irq_o
);

    state_t              state_q, state_d;
    logic [AXON_W-1:0]   ptr_q, ptr_d;
    logic                start;
    logic                capture;
    logic                last;
    logic [N_AXONS-1:0]  axon_in;

    snn_sched_regs #(
        .BASE_ADDR (BASE_ADDR),
        .N_AXONS   (N_AXONS),
        .N_NEURONS (N_NEURONS),
        .AXON_W    (AXON_W)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .busy      (busy_o),
        .ptr       (ptr_q),
        .capture   (capture),
        .spike_i   (spike_i),
        .start     (start),
        .axon_in   (axon_in),
        .irq_o     (irq_o)
    );

    assign last = (ptr_q == AXON_W'(N_AXONS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        axon_req_o     = 1'b0;
        integrate_en_o = '0;
        fire_o         = 1'b0;
        capture        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                end
            end
            ST_SCAN: begin
                if (axon_in[ptr_q]) begin
                    state_d = ST_FETCH;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = last ? ST_FIRE : ST_SCAN;
                end
            end
            ST_FETCH: begin
                axon_req_o = 1'b1;
                state_d    = ST_INTEG;
            end
            ST_INTEG: begin
                integrate_en_o = conn_i;
                ptr_d          = ptr_q + 1'b1;
                state_d        = last ? ST_FIRE : ST_SCAN;
            end
            ST_FIRE: begin
                fire_o  = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign axon_idx_o = ptr_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed self-checking bench for snn_timestep_scheduler.
module tb_snn_timestep_scheduler;

    localparam logic [31:0] BASE = 32'h3000_C000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_SPK  = BASE + 32'h08;
    localparam logic [31:0] A_AXN  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  axon_idx;
    logic        axon_req;
    logic [31:0] conn = '0;
    logic [31:0] integ;
    logic        fire;
    logic [31:0] spike = '0;
    logic        busy, irq;

    int total = 0;
    int bad = 0;
    int busy_cnt, fire_cnt, fire_at, req_cnt, overlap;
    logic [31:0] integ_q[$];
    logic [31:0] rd;

    snn_timestep_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wbs_cyc_i      (cyc),
        .wbs_stb_i      (stb),
        .wbs_we_i       (we),
        .wbs_sel_i      (sel),
        .wbs_adr_i      (adr),
        .wbs_dat_i      (wdat),
        .wbs_ack_o      (ack),
        .wbs_dat_o      (rdat),
        .axon_idx_o     (axon_idx),
        .axon_req_o     (axon_req),
        .conn_i         (conn),
        .integrate_en_o (integ),
        .fire_o         (fire),
        .spike_i        (spike),
        .busy_o         (busy),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] conn_of(input logic [7:0] idx);
        case (idx)
            8'd0:    conn_of = 32'h0000_0001;
            8'd2:    conn_of = 32'h8000_0000;
            8'd128:  conn_of = 32'h0000_0F00;
            8'd255:  conn_of = 32'h0000_0000;
            default: conn_of = 32'h0100_0000 | 32'(idx);
        endcase
    endfunction

    always @(posedge clk) begin
        if (axon_req) conn <= conn_of(axon_idx);
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (fire) begin
            fire_cnt++;
            fire_at = busy_cnt;
        end
        if (axon_req) req_cnt++;
        if (integ != 0) integ_q.push_back(integ);
        if (fire && integ != 0) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        busy_cnt = 0;
        fire_cnt = 0;
        fire_at  = 0;
        req_cnt  = 0;
        overlap  = 0;
        integ_q.delete();
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        int n;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        chk("wb_ack", {31'd0, ack}, 32'd1);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, s, dummy);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_xfer(1'b0, a, 32'h0, 4'hF, r);
    endtask

    task automatic start_run(input logic [31:0] ctrl);
        clear_mon();
        wb_write(A_CTRL, ctrl, 4'hF);
        chk("busy_on_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clear_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fire", {31'd0, fire}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_req", {31'd0, axon_req}, 32'd0);
        wb_read(A_CTRL, rd); chk("rst_ctrl", rd, 32'h0);
        wb_read(A_STAT, rd); chk("rst_status", rd, 32'h0);
        wb_read(A_SPK, rd);  chk("rst_spike", rd, 32'h0);
        for (int w = 0; w < 8; w++) begin
            wb_read(A_AXN + 32'(4 * w), rd);
            chk($sformatf("rst_axon%0d", w), rd, 32'h0);
        end

        // All-zero vector: scan only, fire still issued.
        spike = 32'h0000_1234;
        start_run(32'h1);
        wait_idle(1000);
        chk("zero_busy_len", busy_cnt, 32'd258);
        chk("zero_req", req_cnt, 32'd0);
        chk("zero_fire_cnt", fire_cnt, 32'd1);
        chk("zero_fire_at", fire_at, 32'd257);
        wb_read(A_STAT, rd); chk("zero_status", rd, 32'h0001_0002);
        wb_read(A_SPK, rd);  chk("zero_spike", rd, 32'h0000_1234);

        // Axons 0 and 2 active.
        wb_write(A_AXN, 32'h0000_0005, 4'hF);
        wb_read(A_AXN, rd); chk("axon0_rb", rd, 32'h0000_0005);
        start_run(32'h1);
        wait_idle(1000);
        chk("two_busy_len", busy_cnt, 32'd262);
        chk("two_req", req_cnt, 32'd2);
        chk("two_fire_cnt", fire_cnt, 32'd1);
        chk("two_fire_at", fire_at, 32'd261);
        chk("two_overlap", overlap, 32'd0);
        chk("two_integ_n", integ_q.size(), 32'd2);
        if (integ_q.size() == 2) begin
            chk("two_integ0", integ_q[0], 32'h0000_0001);
            chk("two_integ1", integ_q[1], 32'h8000_0000);
        end
        wb_read(A_STAT, rd); chk("two_status", rd, 32'h0002_0002);

        // Replay with IRQ enabled; check registered irq and CLR_DONE.
        spike = 32'hA5A5_0001;
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_read(A_STAT, rd); chk("pre_irq_status", rd, 32'h0002_0002);
        start_run(32'h3);
        wait_idle(1000);
        chk("irq_first_idle", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        chk("replay_busy_len", busy_cnt, 32'd262);
        chk("replay_integ_n", integ_q.size(), 32'd2);
        wb_read(A_SPK, rd);  chk("irq_spike", rd, 32'hA5A5_0001);
        wb_read(A_CTRL, rd); chk("irq_ctrl_rb", rd, 32'h0000_0002);
        wb_write(A_CTRL, 32'h6, 4'hF);
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        wb_read(A_STAT, rd); chk("clr_status", rd, 32'h0003_0000);

        // Last axon active with an empty row; START and AXON_IN writes while busy ignored.
        wb_write(A_AXN + 32'h1C, 32'h80FF_FFFF, 4'b1000);
        wb_read(A_AXN + 32'h1C, rd); chk("sel_byte3", rd, 32'h8000_0000);
        start_run(32'h1);
        wb_write(A_AXN + 32'h1C, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        wb_read(A_STAT, rd); chk("mid_status", rd & 32'h3, 32'h1);
        wait_idle(1000);
        chk("busy_wr_len", busy_cnt, 32'd264);
        chk("busy_wr_req", req_cnt, 32'd3);
        chk("busy_wr_fire", fire_cnt, 32'd1);
        chk("busy_wr_fire_at", fire_at, 32'd263);
        chk("busy_wr_integ_n", integ_q.size(), 32'd2);
        wb_read(A_AXN + 32'h1C, rd); chk("axon7_kept", rd, 32'h8000_0000);
        wb_read(A_STAT, rd); chk("busy_wr_status", rd, 32'h0004_0002);

        // Reset during INTEG of axon 128.
        wb_write(A_AXN + 32'h10, 32'h0000_0001, 4'hF);
        start_run(32'h1);
        begin
            int n = 0;
            while (!(axon_idx == 8'd128 && integ != 0) && n < 600) begin
                @(negedge clk);
                n++;
            end
            chk("reach_axon128", {24'd0, axon_idx}, 32'd128);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_integ", integ, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_fire", fire_cnt, 32'd0);
        wb_read(A_AXN, rd);         chk("rst_mid_axon0", rd, 32'h0);
        wb_read(A_AXN + 32'h10, rd); chk("rst_mid_axon4", rd, 32'h0);
        wb_read(A_STAT, rd);        chk("rst_mid_status", rd, 32'h0);
        wb_read(A_CTRL, rd);        chk("rst_mid_ctrl", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_timestep_scheduler.md
# snn_timestep_scheduler

Sequencer for one SNN timestep on the 256-axon × 32-neuron core.
- Host loads a 256-bit input-spike vector and writes START over Wishbone.
- The block scans axons 0..255, fetches each active axon's synapse row and pulses per-neuron integrate enables.
- It then issues one fire/leak strobe and latches the 32-bit output-spike vector.
- Placement: beside `neuron_core`, as a Wishbone slave on the same bus, driving the core's row-select and integrate/fire controls.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000C000, Wishbone base of the register window.
- `N_AXONS`, 256, axons per timestep; power of two.
- `N_NEURONS`, 32, neurons; width of connection and spike vectors.
- `AXON_W`, 8, log2(N_AXONS).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  single clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
- Wishbone slave:
  - `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone strobes.
  - `wbs_sel_i`  in  4  byte lanes.
  - `wbs_adr_i`  in  32  byte address.
  - `wbs_dat_i`  in  32  write data.
  - `wbs_ack_o`  out  1  single-cycle ack.
  - `wbs_dat_o`  out  32  read data.
- Core interface:
  - `axon_idx_o`  out  AXON_W  synapse row being fetched.
  - `axon_req_o`  out  1  row-read strobe; the row is returned on `conn_i` the next cycle.
  - `conn_i`  in  N_NEURONS  synapse row (neurons connected to `axon_idx_o`).
  - `integrate_en_o`  out  N_NEURONS  per-neuron integrate pulse.
  - `fire_o`  out  1  end-of-timestep leak/threshold/reset strobe.
  - `spike_i`  in  N_NEURONS  neuron spike outputs, valid the cycle after `fire_o`.
- Status:
  - `busy_o`  out  1  timestep in progress.
  - `irq_o`  out  1  DONE & IRQ_EN.

## Operation
Register map (word offsets from BASE_ADDR):
- 0x00 CTRL
  - bit0 START: write-1 pulse, reads 0.
  - bit1 IRQ_EN: R/W.
  - bit2 CLR_DONE: write-1 pulse.
- 0x04 STATUS (read-only)
  - bit0 BUSY.
  - bit1 DONE.
  - [15:8] current axon pointer.
  - [31:16] TS_COUNT, completed timesteps, wraps at 16 bits.
- 0x08 SPIKE_OUT (read-only): latched `spike_i`.
- 0x10–0x2C AXON_IN[0..7], R/W: AXON_IN[w] bit b is axon 32w+b. Honours `wbs_sel_i`.
- Other offsets in the window read 0; writes to them are ignored.

Register write rules:
- Writes to AXON_IN while BUSY are dropped but still acked.
- AXON_IN is not consumed; a repeated START replays the same vector.

FSM states:
- IDLE: on START → SCAN; ptr=0, DONE cleared.
- SCAN: if AXON_IN[ptr] → FETCH; otherwise advance ptr. Advancing from ptr=N_AXONS-1 → FIRE.
- FETCH: `axon_req_o`=1, `axon_idx_o`=ptr → INTEG.
- INTEG: `integrate_en_o`=`conn_i` for one cycle, then advance ptr (same wrap rule as SCAN).
- FIRE: `fire_o`=1 → CAPTURE.
- CAPTURE: SPIKE_OUT ← `spike_i`, TS_COUNT+1, DONE set → IDLE.

Status rules:
- DONE is sticky; cleared only by CLR_DONE or START.
- If CLR_DONE is written in the same cycle as CAPTURE, set wins.

Boundary conditions:
- START while BUSY: ignored; no restart, no error.
- All-zero AXON_IN: no FETCH/INTEG; FIRE still issued, so leak still applies.
- A row with `conn_i`=0 still costs its FETCH and INTEG cycles.
- Reset mid-timestep: FSM returns to IDLE immediately; no `fire_o`; all registers clear.

## Timing
- Reset values: all outputs 0, CTRL/STATUS/SPIKE_OUT/AXON_IN/TS_COUNT 0, FSM IDLE.
- Wishbone:
  - `wbs_ack_o` rises one cycle after `cyc&stb&!ack`, for one cycle.
  - Read data is valid with ack.
  - A register write takes effect at the ack edge.
- Timestep latency:
  - START ack edge → `busy_o`=1 on the next cycle.
  - `busy_o` stays high for exactly N_AXONS + 2k + 2 cycles, where k = popcount(AXON_IN).
- `busy_o` = (state != IDLE).
- `fire_o` and `integrate_en_o` are never high in the same cycle.
- SPIKE_OUT and DONE are visible on the first IDLE cycle.
- `irq_o` is registered, so it rises one cycle after DONE when IRQ_EN=1.

## Structure
- Shared package `snn_pkg`:
  - FSM state enum.
  - Register offsets (CTRL/STATUS/SPIKE_OUT/AXON_IN).
  - CTRL bit positions.
  - N_AXONS/N_NEURONS defaults.
- One sub-module: `snn_sched_regs`, holding the Wishbone decode, register file and ack generation.
- The FSM and axon pointer stay in the top module.

## Test plan
- Reset, then read all registers → all 0; `busy_o`=0, `irq_o`=0.
- AXON_IN[0]=0x00000005 (axons 0 and 2), conn model returns 32'h1 for axon 0 and 32'h8000_0000 for axon 2, START → `integrate_en_o` pulses 32'h1 then 32'h8000_0000; `busy_o` lasts 256+4+2=262 cycles; exactly one `fire_o`.
- All-zero AXON_IN, START → no `axon_req_o`; `fire_o` after 256 SCAN cycles; DONE=1, TS_COUNT=1.
- `spike_i`=32'hA5A5_0001 during CAPTURE with IRQ_EN=1 → SPIKE_OUT reads 32'hA5A5_0001; `irq_o`=1; CLR_DONE deasserts `irq_o`.
- START and an AXON_IN[7] write while BUSY → both acked, both ignored; the run and the register contents are unchanged.
- Deassert `rst_n` during INTEG of axon 128 → no `fire_o`, FSM in IDLE, AXON_IN=0, TS_COUNT unchanged at 0.
